// File: rtl/ota_sc_phase_ctrl.sv
// ota_sc_phase_ctrl: bias power-up sequencer and non-overlapping
// two-phase clock generator for the switched-capacitor filter OTA.
module ota_sc_phase_ctrl #(
   parameter int KICK_CYC   = 4,
   parameter int SETTLE_CYC = 32,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [7:0]       ph_len,
   input  logic [3:0]       nov,
   output logic             bias_en,
   output logic             bias_kick,
   output logic             phi1,
   output logic             phi1e,
   output logic             phi2,
   output logic             ready,
   output logic             sample_valid,
   output logic [CNT_W-1:0] period_cnt
);

   localparam int TW = 16;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_KICK   = 3'd1;
   localparam logic [2:0] S_SETTLE = 3'd2;
   localparam logic [2:0] S_RUN    = 3'd3;
   localparam logic [2:0] S_DRAIN  = 3'd4;

   localparam logic [1:0] P_P1 = 2'd0;
   localparam logic [1:0] P_D1 = 2'd1;
   localparam logic [1:0] P_P2 = 2'd2;
   localparam logic [1:0] P_D2 = 2'd3;

   localparam logic [TW-1:0] KICK_LD   = TW'(KICK_CYC - 1);
   localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE_CYC - 1);

   logic [1:0]       rel_q, rel_d;
   logic             en_q, en_d;
   logic [2:0]       state_q, state_d;
   logic [1:0]       sub_q, sub_d;
   logic [TW-1:0]    tmr_q, tmr_d;
   logic [7:0]       len_q, len_d;
   logic [3:0]       nv_q, nv_d;
   logic [CNT_W-1:0] pcnt_q, pcnt_d;

   logic bias_en_q, bias_en_d;
   logic kick_q, kick_d;
   logic phi1_q, phi1_d;
   logic phi1e_q, phi1e_d;
   logic phi2_q, phi2_d;
   logic ready_q, ready_d;
   logic sv_q, sv_d;

   logic [TW-1:0] len_ld, nv_ld, tmr_dec;
   logic          tmr_done, go, sv_ev;

   assign len_ld   = TW'(len_q) - TW'(1);
   assign nv_ld    = TW'(nv_q) - TW'(1);
   assign tmr_dec  = tmr_q - TW'(1);
   assign tmr_done = (tmr_q == '0);
   // en is only honoured once the reset release has fully propagated
   assign go       = en_q & rel_q[1];

   always_comb begin
      rel_d   = {rel_q[0], 1'b1};
      en_d    = en & rel_q[0];
      state_d = state_q;
      sub_d   = sub_q;
      tmr_d   = tmr_q;
      len_d   = len_q;
      nv_d    = nv_q;
      pcnt_d  = pcnt_q;
      sv_ev   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (go) begin
               state_d = S_KICK;
               tmr_d   = KICK_LD;
               len_d   = (ph_len == 8'd0) ? 8'd1 : ph_len;
               nv_d    = (nov == 4'd0) ? 4'd1 : nov;
            end
         end
         S_KICK: begin
            if (!en_q) begin
               state_d = S_IDLE;
            end else if (tmr_done) begin
               state_d = S_SETTLE;
               tmr_d   = SETTLE_LD;
            end else begin
               tmr_d = tmr_dec;
            end
         end
         S_SETTLE: begin
            if (!en_q) begin
               state_d = S_IDLE;
            end else if (tmr_done) begin
               state_d = S_RUN;
               sub_d   = P_P1;
               tmr_d   = len_ld;
               pcnt_d  = '0;
            end else begin
               tmr_d = tmr_dec;
            end
         end
         S_RUN: begin
            if (!en_q) begin
               state_d = S_DRAIN;
               tmr_d   = nv_ld;
            end else if (tmr_done) begin
               unique case (sub_q)
                  P_P1: begin
                     sub_d = P_D1;
                     tmr_d = nv_ld;
                  end
                  P_D1: begin
                     sub_d = P_P2;
                     tmr_d = len_ld;
                  end
                  P_P2: begin
                     sub_d  = P_D2;
                     tmr_d  = nv_ld;
                     pcnt_d = pcnt_q + CNT_W'(1);
                     sv_ev  = 1'b1;
                  end
                  default: begin
                     sub_d = P_P1;
                     tmr_d = len_ld;
                  end
               endcase
            end else begin
               tmr_d = tmr_dec;
            end
         end
         S_DRAIN: begin
            if (tmr_done) begin
               state_d = S_IDLE;
            end else begin
               tmr_d = tmr_dec;
            end
         end
         default: begin
            state_d = S_IDLE;
            tmr_d   = '0;
         end
      endcase
   end

   // outputs decoded from next state so every pin comes straight off a flop
   always_comb begin
      bias_en_d = (state_d != S_IDLE);
      kick_d    = (state_d == S_KICK);
      ready_d   = (state_d == S_RUN);
      phi1_d    = ready_d && (sub_d == P_P1);
      phi1e_d   = phi1_d && (tmr_d != '0);
      phi2_d    = ready_d && (sub_d == P_P2);
      sv_d      = sv_ev;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rel_q     <= '0;
         en_q      <= 1'b0;
         state_q   <= S_IDLE;
         sub_q     <= P_P1;
         tmr_q     <= '0;
         len_q     <= 8'd1;
         nv_q      <= 4'd1;
         pcnt_q    <= '0;
         bias_en_q <= 1'b0;
         kick_q    <= 1'b0;
         phi1_q    <= 1'b0;
         phi1e_q   <= 1'b0;
         phi2_q    <= 1'b0;
         ready_q   <= 1'b0;
         sv_q      <= 1'b0;
      end else begin
         rel_q     <= rel_d;
         en_q      <= en_d;
         state_q   <= state_d;
         sub_q     <= sub_d;
         tmr_q     <= tmr_d;
         len_q     <= len_d;
         nv_q      <= nv_d;
         pcnt_q    <= pcnt_d;
         bias_en_q <= bias_en_d;
         kick_q    <= kick_d;
         phi1_q    <= phi1_d;
         phi1e_q   <= phi1e_d;
         phi2_q    <= phi2_d;
         ready_q   <= ready_d;
         sv_q      <= sv_d;
      end
   end

   assign bias_en      = bias_en_q;
   assign bias_kick    = kick_q;
   assign phi1         = phi1_q;
   assign phi1e        = phi1e_q;
   assign phi2         = phi2_q;
   assign ready        = ready_q;
   assign sample_valid = sv_q;
   assign period_cnt   = pcnt_q;

endmodule

// File: tb/tb_ota_sc_phase_ctrl.sv
// tb_ota_sc_phase_ctrl: event scoreboard bench for ota_sc_phase_ctrl;
// expected output edges are queued with their cycle and matched on arrival.
module tb_ota_sc_phase_ctrl;

   localparam int KC = 4;
   localparam int SC = 32;
   localparam int CW = 4;

   localparam int K_BON  = 0;
   localparam int K_BOFF = 1;
   localparam int K_KF   = 2;
   localparam int K_P1R  = 3;
   localparam int K_P1F  = 4;
   localparam int K_E1F  = 5;
   localparam int K_P2R  = 6;
   localparam int K_P2F  = 7;
   localparam int K_SV   = 8;

   typedef struct {
      int k;
      int c;
      int v;
   } ev_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          en = 1'b0;
   logic [7:0]    ph_len = 8'd0;
   logic [3:0]    nov = 4'd0;
   logic          bias_en, bias_kick, phi1, phi1e, phi2;
   logic          ready, sample_valid;
   logic [CW-1:0] period_cnt;

   int  cyc = 0;
   int  checks = 0;
   int  errors = 0;
   ev_t sb[$];

   logic pv_be = 1'b0, pv_bk = 1'b0, pv_p1 = 1'b0;
   logic pv_e1 = 1'b0, pv_p2 = 1'b0;

   string knm[9] = '{"bias_en_rise", "bias_en_fall", "kick_fall",
                     "phi1_rise", "phi1_fall", "phi1e_fall",
                     "phi2_rise", "phi2_fall", "sample_valid"};

   ota_sc_phase_ctrl #(
      .KICK_CYC(KC),
      .SETTLE_CYC(SC),
      .CNT_W(CW)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .en(en),
      .ph_len(ph_len),
      .nov(nov),
      .bias_en(bias_en),
      .bias_kick(bias_kick),
      .phi1(phi1),
      .phi1e(phi1e),
      .phi2(phi2),
      .ready(ready),
      .sample_valid(sample_valid),
      .period_cnt(period_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin : mon
      logic [8:0] det;
      int idx;
      det = '0;
      det[K_BON]  = bias_en & ~pv_be;
      det[K_BOFF] = ~bias_en & pv_be;
      det[K_KF]   = ~bias_kick & pv_bk;
      det[K_P1R]  = phi1 & ~pv_p1;
      det[K_P1F]  = ~phi1 & pv_p1;
      det[K_E1F]  = ~phi1e & pv_e1;
      det[K_P2R]  = phi2 & ~pv_p2;
      det[K_P2F]  = ~phi2 & pv_p2;
      det[K_SV]   = sample_valid;
      checks++;
      if ((phi1 & phi2) | (phi1e & ~phi1) | (bias_kick & ~bias_en) |
          (sample_valid & ~ready) | (phi1e & ~pv_e1 & ~det[K_P1R]) |
          (bias_kick & ~pv_bk & ~det[K_BON])) begin
         errors++;
         $display("FAIL invariant cyc %0d: p1=%b p1e=%b p2=%b kick=%b be=%b sv=%b rdy=%b",
                  cyc, phi1, phi1e, phi2, bias_kick, bias_en,
                  sample_valid, ready);
      end
      for (int k = 0; k < 9; k++) begin
         if (det[k]) begin
            idx = -1;
            foreach (sb[i]) if (idx < 0 && sb[i].k == k) idx = i;
            checks++;
            if (idx < 0) begin
               errors++;
               $display("FAIL %s unexpected at cyc %0d, required none",
                        knm[k], cyc);
            end else begin
               if (sb[idx].c != cyc ||
                   (k == K_SV && sb[idx].v != int'(period_cnt))) begin
                  errors++;
                  $display("FAIL %s at cyc %0d cnt %0d, required cyc %0d cnt %0d",
                           knm[k], cyc, period_cnt, sb[idx].c, sb[idx].v);
               end
               sb.delete(idx);
            end
         end
      end
      pv_be <= bias_en;
      pv_bk <= bias_kick;
      pv_p1 <= phi1;
      pv_e1 <= phi1e;
      pv_p2 <= phi2;
   end

   function automatic void push(input int k, input int c, input int v);
      ev_t e;
      e.k = k;
      e.c = c;
      e.v = v;
      sb.push_back(e);
   endfunction

   task automatic push_period(input int p0, input int l, input int n,
                              input int cnt);
      push(K_P1R, p0, 0);
      if (l > 1) push(K_E1F, p0 + l - 1, 0);
      push(K_P1F, p0 + l, 0);
      push(K_P2R, p0 + l + n, 0);
      push(K_P2F, p0 + 2*l + n, 0);
      push(K_SV, p0 + 2*l + n, cnt % (1 << CW));
   endtask

   task automatic wait_cyc(input int target);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (cyc < target && n < 5000);
      checks++;
      if (cyc != target) begin
         errors++;
         $display("FAIL wait_cyc reached %0d, required %0d", cyc, target);
      end
   endtask

   task automatic test_reset();
      int c;
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if ({bias_en, bias_kick, phi1, phi1e, phi2, ready, sample_valid} !== 7'd0
          || period_cnt !== '0) begin
         errors++;
         $display("FAIL reset_outputs got %b/%0d, required 0/0",
                  {bias_en, bias_kick, phi1, phi1e, phi2, ready, sample_valid},
                  period_cnt);
      end
      repeat (3) @(negedge clk);
      en = 1'b1;
      ph_len = 8'd1;
      nov = 4'd1;
      rst_n = 1'b1;
      c = cyc;
      push(K_BON, c + 3, 0);
      push(K_KF, c + 6, 0);
      push(K_BOFF, c + 6, 0);
      wait_cyc(c + 4);
      en = 1'b0;
      wait_cyc(c + 10);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL reset_release pending %0d events, required 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_reset_mid_run();
      int t, p0, p3;
      @(negedge clk);
      ph_len = 8'd3;
      nov = 4'd2;
      en = 1'b1;
      t = cyc + 1;
      push(K_BON, t + 1, 0);
      push(K_KF, t + 1 + KC, 0);
      p0 = t + 1 + KC + SC;
      for (int p = 0; p < 3; p++) push_period(p0 + 10*p, 3, 2, p + 1);
      p3 = p0 + 30;
      push(K_P1R, p3, 0);
      push(K_E1F, p3 + 2, 0);
      push(K_P1F, p3 + 2, 0);
      push(K_BOFF, p3 + 2, 0);
      wait_cyc(p0);
      checks++;
      if (!(phi1 === 1'b1 && phi1e === 1'b1 && period_cnt === '0)) begin
         errors++;
         $display("FAIL run_entry p1=%b p1e=%b cnt=%0d, required 1 1 0",
                  phi1, phi1e, period_cnt);
      end
      wait_cyc(p3 + 1);
      checks++;
      if (!(ready === 1'b1 && phi1 === 1'b1 && period_cnt === CW'(3))) begin
         errors++;
         $display("FAIL mid_run rdy=%b p1=%b cnt=%0d, required 1 1 3",
                  ready, phi1, period_cnt);
      end
      #2 rst_n = 1'b0;
      en = 1'b0;
      #1;
      checks++;
      if ({bias_en, bias_kick, phi1, phi1e, phi2, ready, sample_valid} !== 7'd0
          || period_cnt !== '0) begin
         errors++;
         $display("FAIL reset_mid_run got %b/%0d, required 0/0",
                  {bias_en, bias_kick, phi1, phi1e, phi2, ready, sample_valid},
                  period_cnt);
      end
      wait_cyc(p3 + 3);
      rst_n = 1'b1;
      wait_cyc(p3 + 8);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL reset_mid_run pending %0d events, required 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic run_cfg(input logic [7:0] pl, input logic [3:0] nv,
                          input int nper, input logic [7:0] pl2,
                          input logic [3:0] nv2, input string nm);
      int t, l, n, p0, pn;
      l = (pl == 8'd0) ? 1 : int'(pl);
      n = (nv == 4'd0) ? 1 : int'(nv);
      @(negedge clk);
      ph_len = pl;
      nov = nv;
      en = 1'b1;
      t = cyc + 1;
      push(K_BON, t + 1, 0);
      push(K_KF, t + 1 + KC, 0);
      p0 = t + 1 + KC + SC;
      for (int p = 0; p < nper; p++)
         push_period(p0 + p*(2*l + 2*n), l, n, p + 1);
      pn = p0 + nper*(2*l + 2*n);
      push(K_BOFF, pn + n, 0);
      wait_cyc(t + 2);
      ph_len = pl2;
      nov = nv2;
      wait_cyc(p0);
      checks++;
      if (!(ready === 1'b1 && phi1 === 1'b1 && period_cnt === '0)) begin
         errors++;
         $display("FAIL %s_entry rdy=%b p1=%b cnt=%0d, required 1 1 0",
                  nm, ready, phi1, period_cnt);
      end
      wait_cyc(pn - 2);
      en = 1'b0;
      wait_cyc(pn + n + 2);
      checks++;
      if (period_cnt !== CW'(nper)) begin
         errors++;
         $display("FAIL %s_hold cnt=%0d, required %0d",
                  nm, period_cnt, nper % (1 << CW));
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL %s pending %0d events, required 0", nm, sb.size());
         sb.delete();
      end
   endtask

   task automatic test_stop_p2();
      int t, p0, p1, t2, q0, qn;
      @(negedge clk);
      ph_len = 8'd5;
      nov = 4'd3;
      en = 1'b1;
      t = cyc + 1;
      push(K_BON, t + 1, 0);
      push(K_KF, t + 1 + KC, 0);
      p0 = t + 1 + KC + SC;
      push_period(p0, 5, 3, 1);
      p1 = p0 + 16;
      push(K_P1R, p1, 0);
      push(K_E1F, p1 + 4, 0);
      push(K_P1F, p1 + 5, 0);
      push(K_P2R, p1 + 8, 0);
      push(K_P2F, p1 + 10, 0);
      push(K_BOFF, p1 + 13, 0);
      wait_cyc(p1 + 8);
      en = 1'b0;
      wait_cyc(p1 + 10);
      checks++;
      if (!(phi2 === 1'b0 && ready === 1'b0 && bias_en === 1'b1 &&
            period_cnt === CW'(1))) begin
         errors++;
         $display("FAIL drain p2=%b rdy=%b be=%b cnt=%0d, required 0 0 1 1",
                  phi2, ready, bias_en, period_cnt);
      end
      wait_cyc(p1 + 11);
      en = 1'b1;
      wait_cyc(p1 + 13);
      checks++;
      if (bias_en !== 1'b0) begin
         errors++;
         $display("FAIL drain_end bias_en=%b, required 0", bias_en);
      end
      t2 = p1 + 13;
      push(K_BON, t2 + 1, 0);
      push(K_KF, t2 + 1 + KC, 0);
      q0 = t2 + 1 + KC + SC;
      push_period(q0, 5, 3, 1);
      qn = q0 + 16;
      push(K_BOFF, qn + 3, 0);
      wait_cyc(q0);
      checks++;
      if (period_cnt !== '0) begin
         errors++;
         $display("FAIL restart_cnt got %0d, required 0", period_cnt);
      end
      wait_cyc(qn - 2);
      en = 1'b0;
      wait_cyc(qn + 5);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL stop_p2 pending %0d events, required 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_abort_settle();
      int t;
      @(negedge clk);
      ph_len = 8'd3;
      nov = 4'd2;
      en = 1'b1;
      t = cyc + 1;
      push(K_BON, t + 1, 0);
      push(K_KF, t + 1 + KC, 0);
      push(K_BOFF, t + 15, 0);
      wait_cyc(t + 13);
      en = 1'b0;
      wait_cyc(t + 15);
      checks++;
      if ({bias_en, bias_kick, phi1, phi1e, phi2, ready, sample_valid}
          !== 7'd0) begin
         errors++;
         $display("FAIL abort_outputs got %b, required 0",
                  {bias_en, bias_kick, phi1, phi1e, phi2, ready, sample_valid});
      end
      wait_cyc(t + 60);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL abort_settle pending %0d events, required 0", sb.size());
         sb.delete();
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at cyc %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_reset_mid_run();
      run_cfg(8'd0, 4'd0, 5, 8'd0, 4'd0, "zero_cfg");
      test_stop_p2();
      test_abort_settle();
      run_cfg(8'd1, 4'd1, 17, 8'd1, 4'd1, "wrap");
      run_cfg(8'd1, 4'd1, 1, 8'd1, 4'd1, "wrap_restart");
      run_cfg(8'd2, 4'd1, 3, 8'd7, 4'd5, "cfg_change");
      run_cfg(8'd7, 4'd5, 2, 8'd7, 4'd5, "cfg_new");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
